// File: rtl/sram_bus_master.sv
`default_nettype none
// ============================================================================
// sram_bus_master : valid/ready request port to asynchronous SRAM bus cycles
// Revision: 1.0
// ============================================================================
module sram_bus_master #(
  parameter int ADDR_W     = 22,
  parameter int DATA_W     = 16,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_be,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_data_oe,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              mem_ce_n,
  output logic              mem_ce2,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic              mem_lb_n,
  output logic              mem_ub_n
);

  localparam int MAX_SP  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int LANE_W  = DATA_W / 2;

  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          be_q, be_d;
  logic [DATA_W-1:0]   cap_q, cap_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                done_q, done_d;
  logic                ce_n_q, ce_n_d;
  logic                ce2_q, ce2_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                lb_n_q, lb_n_d;
  logic                ub_n_q, ub_n_d;
  logic                data_oe_q, data_oe_d;
  logic [DATA_W-1:0]   lane_mask;
  logic                in_cycle;

  assign lane_mask = {{LANE_W{be_q[1]}}, {LANE_W{be_q[0]}}};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    cap_d   = cap_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = SETUP;
          cnt_d   = '0;
          we_d    = req_we;
          addr_d  = req_addr;
          be_d    = (req_be == 2'b00) ? 2'b11 : req_be;
          if (req_we) begin
            wdata_d = req_wdata;
          end
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = STROBE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
          // Sample after the full strobe; disabled lanes read back as zero.
          if (!we_q) begin
            cap_d = mem_data_i & lane_mask;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          if (!we_q) begin
            rdata_d = cap_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Bus pins are decoded from the next state so each phase appears right at its edge.
  always_comb begin
    in_cycle  = (state_d != IDLE);
    ce_n_d    = ~in_cycle;
    ce2_d     = in_cycle;
    lb_n_d    = in_cycle ? ~be_d[0] : 1'b1;
    ub_n_d    = in_cycle ? ~be_d[1] : 1'b1;
    data_oe_d = in_cycle & we_d;
    oe_n_d    = ~((state_d == STROBE) & ~we_d);
    we_n_d    = ~((state_d == STROBE) & we_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= 2'b11;
      cap_q     <= '0;
      rdata_q   <= '0;
      done_q    <= 1'b0;
      ce_n_q    <= 1'b1;
      ce2_q     <= 1'b0;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      lb_n_q    <= 1'b1;
      ub_n_q    <= 1'b1;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      cap_q     <= cap_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
      ce_n_q    <= ce_n_d;
      ce2_q     <= ce2_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      lb_n_q    <= lb_n_d;
      ub_n_q    <= ub_n_d;
      data_oe_q <= data_oe_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign done        = done_q;
  assign rdata       = rdata_q;
  assign mem_addr    = addr_q;
  assign mem_data_o  = wdata_q;
  assign mem_data_oe = data_oe_q;
  assign mem_ce_n    = ce_n_q;
  assign mem_ce2     = ce2_q;
  assign mem_oe_n    = oe_n_q;
  assign mem_we_n    = we_n_q;
  assign mem_lb_n    = lb_n_q;
  assign mem_ub_n    = ub_n_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_master.sv
`default_nettype none
// tb_sram_bus_master : two masters (default and 2/3/2 timing) on 64-word SRAM responders,
// checked against a word-array reference model and phase-length expectations.
module tb_sram_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid, req_we;
  logic [21:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;

  logic a_ready, a_done, a_doe, a_ce_n, a_ce2, a_oe_n, a_we_n, a_lb_n, a_ub_n;
  logic b_ready, b_done, b_doe, b_ce_n, b_ce2, b_oe_n, b_we_n, b_lb_n, b_ub_n;
  logic [15:0] a_rdata, a_do, a_di, b_rdata, b_do, b_di;
  logic [21:0] a_addr, b_addr;
  logic a_req_valid, b_req_valid;

  logic o_ready, o_done, o_doe, o_ce_n, o_ce2, o_oe_n, o_we_n, o_lb_n, o_ub_n;
  logic [15:0] o_rdata, o_do;
  logic [21:0] o_addr;

  logic [15:0] a_mem [64] = '{default: 16'h0};
  logic [15:0] b_mem [64] = '{default: 16'h0};
  logic [15:0] ref_mem [2][64] = '{default: 16'h0};
  logic [15:0] last_rd [2] = '{default: 16'h0};
  logic        pl_en = 1'b0;
  logic        pl_sel = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [15:0] pl_data = '0;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign a_req_valid = req_valid & ~sel;
  assign b_req_valid = req_valid & sel;

  sram_bus_master u_dut_a (
    .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .done(a_done), .rdata(a_rdata),
    .mem_addr(a_addr), .mem_data_o(a_do), .mem_data_oe(a_doe), .mem_data_i(a_di),
    .mem_ce_n(a_ce_n), .mem_ce2(a_ce2), .mem_oe_n(a_oe_n), .mem_we_n(a_we_n),
    .mem_lb_n(a_lb_n), .mem_ub_n(a_ub_n)
  );

  sram_bus_master #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .done(b_done), .rdata(b_rdata),
    .mem_addr(b_addr), .mem_data_o(b_do), .mem_data_oe(b_doe), .mem_data_i(b_di),
    .mem_ce_n(b_ce_n), .mem_ce2(b_ce2), .mem_oe_n(b_oe_n), .mem_we_n(b_we_n),
    .mem_lb_n(b_lb_n), .mem_ub_n(b_ub_n)
  );

  assign o_ready = sel ? b_ready : a_ready;
  assign o_done  = sel ? b_done  : a_done;
  assign o_rdata = sel ? b_rdata : a_rdata;
  assign o_addr  = sel ? b_addr  : a_addr;
  assign o_do    = sel ? b_do    : a_do;
  assign o_doe   = sel ? b_doe   : a_doe;
  assign o_ce_n  = sel ? b_ce_n  : a_ce_n;
  assign o_ce2   = sel ? b_ce2   : a_ce2;
  assign o_oe_n  = sel ? b_oe_n  : a_oe_n;
  assign o_we_n  = sel ? b_we_n  : a_we_n;
  assign o_lb_n  = sel ? b_lb_n  : a_lb_n;
  assign o_ub_n  = sel ? b_ub_n  : a_ub_n;

  // Asynchronous SRAM responders: word index is the low six address bits.
  assign a_di = (!a_ce_n && a_ce2 && !a_oe_n) ? a_mem[a_addr[5:0]] : 16'hDEAD;
  assign b_di = (!b_ce_n && b_ce2 && !b_oe_n) ? b_mem[b_addr[5:0]] : 16'hDEAD;

  always @(posedge clk) begin
    if (pl_en && !pl_sel)
      a_mem[pl_idx] <= pl_data;
    else if (!a_ce_n && a_ce2 && !a_we_n && a_doe)
      a_mem[a_addr[5:0]] <= {a_ub_n ? a_mem[a_addr[5:0]][15:8] : a_do[15:8],
                             a_lb_n ? a_mem[a_addr[5:0]][7:0]  : a_do[7:0]};
  end

  always @(posedge clk) begin
    if (pl_en && pl_sel)
      b_mem[pl_idx] <= pl_data;
    else if (!b_ce_n && b_ce2 && !b_we_n && b_doe)
      b_mem[b_addr[5:0]] <= {b_ub_n ? b_mem[b_addr[5:0]][15:8] : b_do[15:8],
                             b_lb_n ? b_mem[b_addr[5:0]][7:0]  : b_do[7:0]};
  end

  task automatic set_mem(input logic s, input logic [21:0] addr, input logic [15:0] data);
    pl_sel  = s;
    pl_idx  = addr[5:0];
    pl_data = data;
    pl_en   = 1'b1;
    ref_mem[int'(s)][addr[5:0]] = data;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  // One full transaction on the selected master with phase measurement.
  task automatic run_txn(input logic we, input logic [21:0] addr, input logic [15:0] wd,
                         input logic [1:0] be, input string tag);
    int s, s_exp, p_exp, h_exp, l_exp;
    int ce_low, strobe, first_strobe, wrong_strobe, doe_cnt, bad_oe, lane_err, addr_err, data_err, done_k;
    logic [1:0]  beff;
    logic [15:0] mask, old, rd_at_done;
    logic        rdy_at_done;
    s     = int'(sel);
    s_exp = sel ? 2 : 1;
    p_exp = sel ? 3 : 2;
    h_exp = sel ? 2 : 1;
    l_exp = s_exp + p_exp + h_exp;
    beff  = (be == 2'b00) ? 2'b11 : be;
    mask  = {{8{beff[1]}}, {8{beff[0]}}};
    old   = ref_mem[s][addr[5:0]];
    if (we) ref_mem[s][addr[5:0]] = (old & ~mask) | (wd & mask);
    else    last_rd[s] = old & mask;
    ce_low = 0; strobe = 0; first_strobe = -1; wrong_strobe = 0; doe_cnt = 0;
    bad_oe = 0; lane_err = 0; addr_err = 0; data_err = 0; done_k = -1;
    rd_at_done = 16'hxxxx; rdy_at_done = 1'b0;

    @(negedge clk);
    for (int i = 0; i < 50 && !o_ready; i++) @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_addr = 22'($urandom); req_wdata = 16'($urandom); req_be = 2'($urandom);

    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (o_done) begin
        done_k = k; rd_at_done = o_rdata; rdy_at_done = o_ready;
        break;
      end
      if (!o_ce_n) begin
        ce_low++;
        if (o_lb_n !== ~beff[0] || o_ub_n !== ~beff[1] || o_ce2 !== 1'b1) lane_err++;
        if (o_addr !== addr) addr_err++;
      end
      if ((we ? o_we_n : o_oe_n) === 1'b0) begin
        if (first_strobe < 0) first_strobe = k;
        strobe++;
      end
      if ((we ? o_oe_n : o_we_n) === 1'b0) wrong_strobe++;
      if (o_doe) begin
        doe_cnt++;
        if (o_do !== wd) data_err++;
        if (o_oe_n === 1'b0) bad_oe++;
      end
    end

    nvec++; if (done_k != l_exp) begin nerr++; $display("FAIL %s done_latency: got %0d want %0d", tag, done_k, l_exp); end
    nvec++; if (ce_low != l_exp) begin nerr++; $display("FAIL %s ce_low_cycles: got %0d want %0d", tag, ce_low, l_exp); end
    nvec++; if (first_strobe != s_exp) begin nerr++; $display("FAIL %s setup_len: got %0d want %0d", tag, first_strobe, s_exp); end
    nvec++; if (strobe != p_exp) begin nerr++; $display("FAIL %s strobe_len: got %0d want %0d", tag, strobe, p_exp); end
    nvec++; if (ce_low - first_strobe - strobe != h_exp) begin nerr++; $display("FAIL %s hold_len: got %0d want %0d", tag, ce_low - first_strobe - strobe, h_exp); end
    nvec++; if (wrong_strobe != 0) begin nerr++; $display("FAIL %s wrong_strobe: got %0d want 0", tag, wrong_strobe); end
    nvec++; if (doe_cnt != (we ? l_exp : 0)) begin nerr++; $display("FAIL %s data_oe_cycles: got %0d want %0d", tag, doe_cnt, we ? l_exp : 0); end
    nvec++; if (bad_oe + lane_err + addr_err + data_err != 0) begin nerr++; $display("FAIL %s bus_values: oe_clash %0d lane %0d addr %0d data %0d want all 0", tag, bad_oe, lane_err, addr_err, data_err); end
    nvec++; if (rd_at_done !== last_rd[s] || rdy_at_done !== 1'b1) begin nerr++; $display("FAIL %s rdata_at_done: got %h ready %b want %h ready 1", tag, rd_at_done, rdy_at_done, last_rd[s]); end
    @(negedge clk);
    nvec++; if (o_rdata !== last_rd[s] || o_ce_n !== 1'b1 || o_done !== 1'b0) begin nerr++; $display("FAIL %s after_done: rdata %h ce_n %b done %b want %h 1 0", tag, o_rdata, o_ce_n, o_done, last_rd[s]); end
  endtask

  task automatic test_reset;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      nvec++;
      if ({o_ready, o_done, o_ce_n, o_ce2, o_oe_n, o_we_n, o_lb_n, o_ub_n, o_doe} !== 9'b101011110) begin
        nerr++;
        $display("FAIL reset_ctl[%0d]: got %b want 101011110", s,
                 {o_ready, o_done, o_ce_n, o_ce2, o_oe_n, o_we_n, o_lb_n, o_ub_n, o_doe});
      end
      nvec++;
      if (o_rdata !== 16'h0 || o_addr !== 22'h0 || o_do !== 16'h0) begin
        nerr++;
        $display("FAIL reset_data[%0d]: rdata %h addr %h data_o %h want all 0", s, o_rdata, o_addr, o_do);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_back_to_back;
    int d1, d2, gaps;
    logic [15:0] rd2;
    sel = 1'b0;
    d1 = -1; d2 = -1; gaps = 0; rd2 = 16'hxxxx;
    ref_mem[0][16] = 16'h0F0F;
    last_rd[0] = 16'h0F0F;
    @(negedge clk);
    for (int i = 0; i < 50 && !o_ready; i++) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 22'h10; req_wdata = 16'h0F0F; req_be = 2'b11;
    @(posedge clk);
    #1 req_we = 1'b0; req_wdata = 16'($urandom);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_done && d1 >= 0) begin
        d2 = k; rd2 = o_rdata;
        break;
      end
      if (o_ce_n) gaps++;
      if (o_done) begin
        d1 = k;
        @(posedge clk);
        #1 req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    nvec++; if (d1 != 4) begin nerr++; $display("FAIL b2b_first_done: got %0d want 4", d1); end
    nvec++; if (d2 - d1 != 5) begin nerr++; $display("FAIL b2b_done_spacing: got %0d want 5", d2 - d1); end
    nvec++; if (gaps != 1) begin nerr++; $display("FAIL b2b_idle_gap: got %0d want 1", gaps); end
    nvec++; if (rd2 !== 16'h0F0F) begin nerr++; $display("FAIL b2b_read_data: got %h want 0f0f", rd2); end
  endtask

  task automatic test_reset_mid_write;
    int dones;
    sel = 1'b0;
    dones = 0;
    @(negedge clk);
    for (int i = 0; i < 50 && !o_ready; i++) @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 22'h2A; req_wdata = 16'hFFFF; req_be = 2'b11;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nvec++; if (o_we_n !== 1'b0) begin nerr++; $display("FAIL rst_pre_strobe: we_n %b want 0", o_we_n); end
    #2 rst = 1'b1;
    #1;
    nvec++;
    if (o_we_n !== 1'b1 || o_ce_n !== 1'b1 || o_doe !== 1'b0 || o_ce2 !== 1'b0 || o_done !== 1'b0) begin
      nerr++;
      $display("FAIL rst_async: we_n %b ce_n %b oe %b ce2 %b done %b want 1 1 0 0 0", o_we_n, o_ce_n, o_doe, o_ce2, o_done);
    end
    last_rd[0] = 16'h0;
    last_rd[1] = 16'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (o_done) dones++;
    end
    nvec++; if (dones != 0 || o_ready !== 1'b1) begin nerr++; $display("FAIL rst_abort: dones %0d ready %b want 0 1", dones, o_ready); end
  endtask

  task automatic test_random(input logic s, input int n);
    sel = s;
    for (int i = 0; i < n; i++) begin
      run_txn(1'($urandom), 22'($urandom), 16'($urandom), 2'($urandom), s ? "rand_b" : "rand_a");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; sel = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = 2'b00;
    repeat (3) @(negedge clk);
    test_reset;
    rst = 1'b0;
    @(negedge clk);
    test_reset;

    sel = 1'b0;
    run_txn(1'b1, 22'd3, 16'hA5C3, 2'b11, "write_default");
    set_mem(1'b0, 22'd3, 16'h1234);
    run_txn(1'b0, 22'd3, 16'h0000, 2'b11, "read_default");
    set_mem(1'b0, 22'd7, 16'hBEEF);
    run_txn(1'b0, 22'd7, 16'h0000, 2'b01, "byte_read_lo");
    run_txn(1'b0, 22'd7, 16'h0000, 2'b10, "byte_read_hi");
    run_txn(1'b1, 22'd9, 16'hC0DE, 2'b10, "byte_write_hi");
    run_txn(1'b0, 22'd9, 16'h0000, 2'b00, "read_be00");
    test_back_to_back;
    test_reset_mid_write;

    sel = 1'b1;
    run_txn(1'b1, 22'h3FFFC5, 16'h5AA5, 2'b00, "param_write");
    run_txn(1'b0, 22'h000005, 16'h0000, 2'b11, "param_read");

    test_random(1'b0, 40);
    test_random(1'b1, 30);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
